// File: rtl/mutex_pkg.sv
// Shared types and constants for the hardware mutex requester: FSM states,
// mutex register addresses and owner/value field positions.
package mutex_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_LOCK,
      RD_CHECK,
      BACKOFF,
      FAIL,
      HELD,
      WR_RELEASE
   } mutex_state_e;

   localparam logic MUTEX_ADDR_VALUE = 1'b0;
   localparam logic MUTEX_ADDR_RESET = 1'b1;

   localparam int OWNER_MSB = 31;
   localparam int OWNER_LSB = 16;
   localparam int VALUE_MSB = 15;
   localparam int VALUE_LSB = 0;

   function automatic logic [31:0] mutex_word(input logic [15:0] owner, input logic [15:0] value);
      return {owner, value};
   endfunction

endpackage

// File: rtl/mutex_backoff_timer.sv
// Loadable down-counter; holds at zero and reports it through zero_o.
module mutex_backoff_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] load_value_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_value_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/mutex_hw_requester.sv
// Avalon-MM master that takes and frees the hardware mutex for a local agent:
// lock write, read-back check, backoff/retry on contention, release write.
module mutex_hw_requester
   import mutex_pkg::*;
#(
   parameter logic [15:0] OWNER_ID       = 16'h00F0,
   parameter logic [15:0] LOCK_VALUE     = 16'h0001,
   parameter int          BACKOFF_CYCLES = 16,
   parameter int          MAX_TRIES      = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        acquire,
   input  logic        release_req,
   output logic        granted,
   output logic        busy,
   output logic        fail,
   output logic [7:0]  tries,
   output logic        avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam logic [7:0]  MAX_TRIES_8  = 8'(MAX_TRIES);
   localparam logic [15:0] BACKOFF_LOAD = 16'(BACKOFF_CYCLES - 1);

   mutex_state_e state_q, state_d;
   logic [7:0]   tries_q, tries_d;
   logic         bo_load, bo_dec, bo_zero;
   logic         lock_seen;

   mutex_backoff_timer #(.W(16)) u_backoff (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_i       (bo_load),
      .load_value_i (BACKOFF_LOAD),
      .dec_i        (bo_dec),
      .zero_o       (bo_zero)
   );

   assign lock_seen = (avm_readdata[OWNER_MSB:OWNER_LSB] == OWNER_ID) &&
                      (avm_readdata[VALUE_MSB:VALUE_LSB] == LOCK_VALUE);

   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      bo_load = 1'b0;
      bo_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (acquire) begin
               tries_d = '0;
               state_d = WR_LOCK;
            end
         end
         WR_LOCK: begin
            if (!avm_waitrequest) begin
               if (tries_q != 8'hFF) tries_d = tries_q + 8'd1;
               state_d = RD_CHECK;
            end
         end
         RD_CHECK: begin
            if (!avm_waitrequest) begin
               if (lock_seen) begin
                  state_d = HELD;
               end else if ((MAX_TRIES != 0) && (tries_q == MAX_TRIES_8)) begin
                  state_d = FAIL;
               end else begin
                  bo_load = 1'b1;
                  state_d = BACKOFF;
               end
            end
         end
         BACKOFF: begin
            if (bo_zero) state_d = WR_LOCK;
            else         bo_dec  = 1'b1;
         end
         FAIL:    state_d = IDLE;
         HELD: begin
            if (release_req) state_d = WR_RELEASE;
         end
         WR_RELEASE: begin
            if (!avm_waitrequest) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tries_q <= '0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
      end
   end

   // Outputs decode straight from the state so reset clears them without waiting for a clock.
   always_comb begin
      avm_writedata = '0;
      if (state_q == WR_LOCK)    avm_writedata = mutex_word(OWNER_ID, LOCK_VALUE);
      if (state_q == WR_RELEASE) avm_writedata = mutex_word(OWNER_ID, 16'h0000);
   end

   assign avm_address = MUTEX_ADDR_VALUE;
   assign avm_write   = (state_q == WR_LOCK) || (state_q == WR_RELEASE);
   assign avm_read    = (state_q == RD_CHECK);
   assign granted     = (state_q == HELD);
   assign fail        = (state_q == FAIL);
   assign busy        = (state_q != IDLE) && (state_q != HELD);
   assign tries       = tries_q;

endmodule

// File: tb/tb_mutex_hw_requester.sv
// Bench for mutex_hw_requester: two instances (bounded retries / retry forever)
// share a scripted Avalon slave; scenarios from a table, hand sequences and random runs.
module tb_mutex_hw_requester;

   localparam logic [31:0] W_LOCK  = 32'h00F00001;
   localparam logic [31:0] W_REL   = 32'h00F00000;
   localparam logic [31:0] CONTEND = 32'h00010001;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        acq_a = 0, rel_a = 0, acq_b = 0, rel_b = 0;
   logic        gr_a, busy_a, fail_a, addr_a, rd_a, wr_a;
   logic        gr_b, busy_b, fail_b, addr_b, rd_b, wr_b;
   logic [7:0]  tries_a, tries_b;
   logic [31:0] wd_a, wd_b;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;

   mutex_hw_requester #(.BACKOFF_CYCLES(4), .MAX_TRIES(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .acquire(acq_a), .release_req(rel_a),
      .granted(gr_a), .busy(busy_a), .fail(fail_a), .tries(tries_a),
      .avm_address(addr_a), .avm_read(rd_a), .avm_write(wr_a), .avm_writedata(wd_a),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest));

   mutex_hw_requester #(.BACKOFF_CYCLES(2), .MAX_TRIES(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .acquire(acq_b), .release_req(rel_b),
      .granted(gr_b), .busy(busy_b), .fail(fail_b), .tries(tries_b),
      .avm_address(addr_b), .avm_read(rd_b), .avm_write(wr_b), .avm_writedata(wd_b),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest));

   bit sel = 1'b0;
   logic        m_gr, m_busy, m_fail, m_rd, m_wr, m_addr;
   logic [7:0]  m_tries;
   logic [31:0] m_wd;
   assign m_gr    = sel ? gr_b    : gr_a;
   assign m_busy  = sel ? busy_b  : busy_a;
   assign m_fail  = sel ? fail_b  : fail_a;
   assign m_tries = sel ? tries_b : tries_a;
   assign m_rd    = sel ? rd_b    : rd_a;
   assign m_wr    = sel ? wr_b    : wr_a;
   assign m_addr  = sel ? addr_b  : addr_a;
   assign m_wd    = sel ? wd_b    : wd_a;

   int total = 0, passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scripted slave: per-transfer stall counts and read data come from queues.
   int unsigned  stall_q[$];
   logic [31:0]  rdata_q[$];
   logic [31:0]  wlog[$];
   int           rd_done = 0, unstable = 0, multi = 0, badaddr = 0;
   bit           in_xfer = 0;
   int unsigned  rem = 0;
   logic [34:0]  snap = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         in_xfer = 0;
         avm_waitrequest = 1'b0;
      end else begin
         if (m_rd && m_wr) multi++;
         if ((m_rd || m_wr) && m_addr !== 1'b0) badaddr++;
         if (!in_xfer && (m_rd || m_wr)) begin
            in_xfer = 1;
            rem = (stall_q.size() != 0) ? stall_q.pop_front() : 0;
            snap = {m_rd, m_wr, m_addr, m_wd};
         end
         if (in_xfer) begin
            if ({m_rd, m_wr, m_addr, m_wd} !== snap) unstable++;
            if (rem > 0) begin
               avm_waitrequest = 1'b1;
               rem--;
            end else begin
               avm_waitrequest = 1'b0;
               in_xfer = 0;
               if (m_wr) wlog.push_back(m_wd);
               else begin
                  rd_done++;
                  avm_readdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : CONTEND;
               end
            end
         end else begin
            avm_waitrequest = 1'b0;
         end
      end
   end

   task automatic clear_bus();
      stall_q.delete(); rdata_q.delete(); wlog.delete();
      rd_done = 0; unstable = 0; multi = 0; badaddr = 0;
   endtask

   // Pulse acquire on the selected instance and follow it to grant or give-up.
   task automatic run_acq(input bit s, input bit rel_too, input bit exp_grant,
                          input int exp_tries, input int exp_lat);
      int e;
      int bad;
      sel = s;
      if (s) begin acq_b = 1; rel_b = rel_too; end
      else   begin acq_a = 1; rel_a = rel_too; end
      @(posedge clk); @(negedge clk);
      acq_a = 0; rel_a = 0; acq_b = 0; rel_b = 0;
      chk("busy_after_acquire", m_busy, 1);
      e = 0;
      while (e < 2000 && !m_gr && !m_fail) begin
         @(posedge clk); e++; @(negedge clk);
      end
      $display("acquire dut=%0d lat=%0d tries=%0d outcome=%s", s, e, m_tries,
               m_gr ? "grant" : (m_fail ? "giveup" : "timeout"));
      chk("latency", e, exp_lat);
      chk("granted", m_gr, exp_grant);
      chk("fail_pulse", m_fail, !exp_grant);
      chk("tries", m_tries, exp_tries);
      chk("lock_writes", wlog.size(), exp_tries);
      chk("check_reads", rd_done, exp_tries);
      bad = 0;
      foreach (wlog[i]) if (wlog[i] !== W_LOCK) bad++;
      chk("lock_writedata", bad, 0);
      chk("bus_rules", unstable + multi + badaddr, 0);
      @(posedge clk); @(negedge clk);
      chk("state_after", {m_gr, m_busy, m_fail}, exp_grant ? 3'b100 : 3'b000);
      chk("tries_hold", m_tries, exp_tries);
   endtask

   task automatic run_rel(input bit s, input bit with_acq);
      int e;
      sel = s;
      if (s) begin rel_b = 1; acq_b = with_acq; end
      else   begin rel_a = 1; acq_a = with_acq; end
      @(posedge clk); @(negedge clk);
      acq_a = 0; rel_a = 0; acq_b = 0; rel_b = 0;
      chk("rel_granted_low", m_gr, 0);
      chk("rel_write", {m_wr, m_rd, m_wd}, {2'b10, W_REL});
      e = 0;
      while (e < 200 && m_busy) begin
         @(posedge clk); e++; @(negedge clk);
      end
      chk("rel_to_idle", {m_busy, m_gr}, 2'b00);
      chk("rel_logged", wlog.size() != 0 ? wlog[$] : 32'hDEAD_BEEF, W_REL);
      repeat (3) @(negedge clk);
      chk("acquire_not_queued", {m_busy, m_gr, m_wr, m_rd}, 4'b0000);
      $display("release dut=%0d acquire_too=%0d cycles=%0d", s, with_acq, e + 1);
   endtask

   typedef struct {
      bit s; int c; int stall; bit rel_too; bit grant; int ntries; int lat;
   } vec_t;
   vec_t vecs[7];

   logic [31:0] bad_words[3];

   initial begin
      int n, lat, c, mt, bo;
      bit s, g;

      vecs[0] = '{s:0, c:0, stall:0, rel_too:0, grant:1, ntries:1, lat:2};
      vecs[1] = '{s:0, c:3, stall:0, rel_too:0, grant:0, ntries:3, lat:14};
      vecs[2] = '{s:1, c:2, stall:0, rel_too:0, grant:1, ntries:3, lat:10};
      vecs[3] = '{s:0, c:0, stall:5, rel_too:0, grant:1, ntries:1, lat:12};
      vecs[4] = '{s:0, c:0, stall:0, rel_too:1, grant:1, ntries:1, lat:2};
      vecs[5] = '{s:0, c:1, stall:1, rel_too:0, grant:1, ntries:2, lat:12};
      vecs[6] = '{s:1, c:0, stall:0, rel_too:1, grant:1, ntries:1, lat:2};
      bad_words[0] = 32'h00010001;
      bad_words[1] = 32'h00F00000;
      bad_words[2] = 32'h00000001;

      #2;
      chk("reset_outputs_a", {gr_a, busy_a, fail_a, tries_a, addr_a, rd_a, wr_a, wd_a}, '0);
      chk("reset_outputs_b", {gr_b, busy_b, fail_b, tries_b, addr_b, rd_b, wr_b, wd_b}, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         clear_bus();
         for (int i = 0; i < vecs[k].ntries; i++) begin
            stall_q.push_back(vecs[k].stall);
            stall_q.push_back(vecs[k].stall);
         end
         for (int i = 0; i < vecs[k].c; i++) rdata_q.push_back(CONTEND);
         rdata_q.push_back(W_LOCK);
         run_acq(vecs[k].s, vecs[k].rel_too, vecs[k].grant, vecs[k].ntries, vecs[k].lat);
         if (vecs[k].grant) run_rel(vecs[k].s, k[0]);
      end

      // Reset while backing off: outputs clear before the next clock edge.
      clear_bus();
      sel = 0;
      acq_a = 1;
      @(posedge clk); @(negedge clk);
      acq_a = 0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("in_backoff", {busy_a, rd_a, wr_a, gr_a}, 4'b1000);
      #1 reset_n = 1'b0;
      #1 chk("async_reset_outputs", {gr_a, busy_a, fail_a, tries_a, addr_a, rd_a, wr_a, wd_a}, '0);
      $display("reset during backoff applied");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {busy_a, gr_a, rd_a, wr_a}, 4'b0000);

      // Random scenarios against an attempt-count / cycle-sum model.
      for (int r = 0; r < 20; r++) begin
         clear_bus();
         s  = 1'($urandom_range(0, 1));
         mt = s ? 0 : 3;
         bo = s ? 2 : 4;
         c  = $urandom_range(0, 4);
         g  = !(mt != 0 && c >= mt);
         n  = g ? c + 1 : mt;
         lat = (n - 1) * bo;
         for (int i = 0; i < n; i++) begin
            int sw, sr;
            sw = $urandom_range(0, 3);
            sr = $urandom_range(0, 3);
            stall_q.push_back(sw);
            stall_q.push_back(sr);
            lat += 2 + sw + sr;
         end
         for (int i = 0; i < c; i++) rdata_q.push_back(bad_words[$urandom_range(0, 2)]);
         rdata_q.push_back(W_LOCK);
         run_acq(s, 1'($urandom_range(0, 1)), g, n, lat);
         if (g) run_rel(s, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mutex_hw_requester.md
Name: mutex_hw_requester

Overview:
- Avalon-MM master that acquires and releases the hardware mutex on behalf of a non-CPU hardware agent, e.g. an image-processing DMA engine sharing a frame buffer with the NIOS cores.
- Issues the owner/value write, reads back to confirm ownership, backs off and retries on contention, and performs the release write.
- Sits between the local agent's simple acquire/release handshake and the system interconnect's mutex s1 slave.

Parameters:
- OWNER_ID, 16'h00F0, owner tag written to bits [31:16]; must differ from every CPU's ID.
- LOCK_VALUE, 16'h0001, value written to bits [15:0] on acquire; must be nonzero.
- BACKOFF_CYCLES, 16, idle cycles between a failed check and the next lock attempt; minimum 1.
- MAX_TRIES, 0, lock attempts before giving up; 0 means retry forever; maximum 255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- acquire  in  1  single-cycle request to take the mutex
- release  in  1  single-cycle request to free the mutex
- granted  out  1  high while the mutex is held by OWNER_ID
- busy  out  1  high in any state other than IDLE or HELD
- fail  out  1  one-cycle pulse when MAX_TRIES is exhausted
- tries  out  8  attempts used in the current or last acquire; saturates at 255
- avm_address  out  1  0 = mutex value/owner word, 1 = reset flag
- avm_read  out  1  read command
- avm_write  out  1  write command
- avm_writedata  out  32  {owner, value}
- avm_readdata  in  32  read data, valid when avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; backoff counter 0.
- Bus rule: a command and its address/data are held stable while avm_waitrequest=1. A transfer completes on the first cycle with waitrequest=0. At most one command is asserted per cycle. Reads are captured on completion.
- avm_address is 0 for every transfer.
- IDLE:
  - acquire=1 -> clear tries, go to WR_LOCK.
  - release is ignored.
- WR_LOCK:
  - Drive write of {OWNER_ID, LOCK_VALUE}.
  - On completion, tries increments (saturating at 255), go to RD_CHECK.
- RD_CHECK:
  - Drive read.
  - On completion, go to HELD if readdata[31:16]==OWNER_ID and readdata[15:0]==LOCK_VALUE.
  - Otherwise go to FAIL if MAX_TRIES!=0 and tries==MAX_TRIES.
  - Otherwise load the backoff counter with BACKOFF_CYCLES-1 and go to BACKOFF.
- BACKOFF:
  - No bus activity; the counter decrements each cycle.
  - At 0, go to WR_LOCK.
- FAIL: fail=1 for exactly one cycle, then IDLE.
- HELD:
  - granted=1.
  - release=1 -> WR_RELEASE.
  - acquire is ignored.
- WR_RELEASE:
  - Drive write of {OWNER_ID, 16'h0000}.
  - granted drops on entry to this state.
  - On completion, go to IDLE.
- Minimum latency from acquire to granted, with zero waitrequest: WR_LOCK 1 cycle + RD_CHECK 1 cycle; granted is high on the 3rd cycle after acquire is sampled.
- Simultaneous acquire and release are resolved by state: in IDLE only acquire acts; in HELD only release acts; in busy states both are ignored and not queued.
- busy=1 in WR_LOCK, RD_CHECK, BACKOFF, FAIL and WR_RELEASE.
- Reset mid-operation returns to IDLE immediately, with commands deasserted. A lock already written stays held in the mutex; software recovers it through the mutex reset flag or an owner-matched release.
- MAX_TRIES=0 never asserts fail.
- tries holds its value after HELD or FAIL until the next acquire.

Decomposition:
- Shared package mutex_pkg:
  - FSM state enum (IDLE, WR_LOCK, RD_CHECK, BACKOFF, FAIL, HELD, WR_RELEASE).
  - Constants MUTEX_ADDR_VALUE=1'b0 and MUTEX_ADDR_RESET=1'b1.
  - Field slices OWNER_MSB=31, OWNER_LSB=16, VALUE_MSB=15, VALUE_LSB=0.
- One sub-module, mutex_backoff_timer: loadable down-counter with load, load value, and a zero flag.

Test Plan:
- Free mutex, no waitrequest: acquire pulse -> write 0x00F00001, read returns 0x00F00001, granted=1 on cycle 3, tries=1.
- Contention with MAX_TRIES=3, BACKOFF_CYCLES=4: read returns 0x00010001 three times -> 4 idle bus cycles between attempts, fail pulses once, tries=3, back in IDLE, granted=0.
- Late free, MAX_TRIES=0: contention for 2 attempts, then the read returns 0x00F00001 -> granted=1, tries=3, fail never asserted.
- Waitrequest held 5 cycles on each transfer -> writedata and command stable throughout; each transfer completes once; the grant arrives 10 cycles later than the zero-stall case.
- Release while HELD -> write 0x00F00000, granted low from the WR_RELEASE cycle, IDLE afterwards.
- Release and acquire both pulsed in IDLE -> only the acquire flow starts.
- reset_n asserted during BACKOFF -> all outputs 0 asynchronously, FSM in IDLE.
